usr_shift_reg: RTL and testbench

Parametrised universal shift register with per-cycle mode select: hold, shift left, shift right or parallel load. It also carries a drain counter that tracks how many loaded bits have not yet been shifted out. It is the multi-bit successor to the team's single-bit reset flop: it keeps the `q`/`qbar` output pair and adds enable, serial I/O and mode control. It sits between parallel datapaths and bit-serial links as a serializer, deserializer or general-purpose staging register.

---
 rtl/usr_pkg.sv | 16 +
 rtl/usr_cell.sv | 42 ++++
 rtl/usr_shift_reg.sv | 97 +++++++++
 tb/tb_usr_shift_reg.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and counter sizing.
package usr_pkg;

  typedef enum logic [1:0] {
    USR_HOLD = 2'b00,
    USR_SHL  = 2'b01,
    USR_SHR  = 2'b10,
    USR_LOAD = 2'b11
  } usr_mode_t;

  // Bits needed to hold 0..width inclusive.
  function automatic int unsigned usr_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_cell.sv
// One register bit: async-reset flop with enable and a mode-driven next-state mux.
module usr_cell
  import usr_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  usr_mode_t sel,
  input  logic      shl_in,
  input  logic      shr_in,
  input  logic      d,
  output logic      q
);

  logic q_d;
  logic q_q;

  // shl_in comes from the lower neighbour, shr_in from the upper one.
  always_comb begin
    q_d = q_q;
    unique case (sel)
      USR_HOLD: q_d = q_q;
      USR_SHL:  q_d = shl_in;
      USR_SHR:  q_d = shr_in;
      USR_LOAD: q_d = d;
      default:  q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_BIT;
    end else if (en) begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/usr_shift_reg.sv
// Universal shift register (hold / shift left / shift right / load) with a drain counter.
// Optional rotate input enabled by defining USR_ROTATE_EN.
module usr_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned          WIDTH   = 8,
  parameter logic [WIDTH-1:0]     RST_VAL = '0,
  localparam int unsigned         CW      = usr_cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
`ifdef USR_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    cnt,
  output logic             drained
);

  localparam logic [CW-1:0] CntFull = CW'(WIDTH);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  usr_mode_t        mode_e;
  logic             shl_in;
  logic             shr_in;
  logic [WIDTH-1:0] shl_vec;
  logic [WIDTH-1:0] shr_vec;
  logic [CW-1:0]    cnt_d;
  logic [CW-1:0]    cnt_q;

  assign mode_e = usr_mode_t'(mode);

`ifdef USR_ROTATE_EN
  assign shl_in = rot ? q[WIDTH-1] : sin_r;
  assign shr_in = rot ? q[0] : sin_l;
`else
  assign shl_in = sin_r;
  assign shr_in = sin_l;
`endif

  assign shl_vec = {q[WIDTH-2:0], shl_in};
  assign shr_vec = {shr_in, q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_cell #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .sel    (mode_e),
      .shl_in (shl_vec[i]),
      .shr_in (shr_vec[i]),
      .d      (d[i]),
      .q      (q[i])
    );
  end

  // Shifts drain toward zero and stick there; a load always restarts from full.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      unique case (mode_e)
        USR_SHL, USR_SHR: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CntOne;
          end
        end
        USR_LOAD: cnt_d = CntFull;
        default:  cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign drained = (cnt_q == '0);
  assign qbar    = ~q;
  assign sout_l  = q[WIDTH-1];
  assign sout_r  = q[0];

endmodule

// File: tb/tb_usr_shift_reg.sv
// Scoreboard bench for usr_shift_reg (WIDTH=8, RST_VAL=0); rotate cases under USR_ROTATE_EN.
module tb_usr_shift_reg;
  import usr_pkg::*;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic [3:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  usr_mode_t  mode = USR_HOLD;
  logic [7:0] d = '0;
  logic       sin_l = 1'b0;
  logic       sin_r = 1'b0;
  logic       rot = 1'b0;
  logic [7:0] q;
  logic [7:0] qbar;
  logic       sout_l;
  logic       sout_r;
  logic [3:0] cnt;
  logic       drained;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  usr_shift_reg #(
    .WIDTH   (8),
    .RST_VAL (8'h00)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .d       (d),
    .sin_l   (sin_l),
    .sin_r   (sin_r),
`ifdef USR_ROTATE_EN
    .rot     (rot),
`endif
    .q       (q),
    .qbar    (qbar),
    .sout_l  (sout_l),
    .sout_r  (sout_r),
    .cnt     (cnt),
    .drained (drained)
  );

  always #5 clk = ~clk;

  // Monitor: compares the full output set whenever an expectation is posted.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      wait (exp_q.size() != 0);
      e  = exp_q.pop_front();
      ok = (q === e.q) && (qbar === ~e.q) && (cnt === e.cnt) &&
           (drained === (e.cnt == 4'd0)) && (sout_l === e.q[7]) && (sout_r === e.q[0]);
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL %s: got q=%h qbar=%h cnt=%0d drained=%b sout_l=%b sout_r=%b, want q=%h qbar=%h cnt=%0d drained=%b sout_l=%b sout_r=%b",
                 e.name, q, qbar, cnt, drained, sout_l, sout_r,
                 e.q, ~e.q, e.cnt, (e.cnt == 4'd0), e.q[7], e.q[0]);
      end
    end
  end

  task automatic expect_now(input string name, input logic [7:0] eq, input logic [3:0] ec);
    exp_t e;
    e.name = name;
    e.q    = eq;
    e.cnt  = ec;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, then post the expected post-edge state.
  task automatic cyc(input string name, input logic en_v, input usr_mode_t m,
                     input logic [7:0] dv, input logic sl, input logic sr, input logic rv,
                     input logic [7:0] eq, input logic [3:0] ec);
    en    = en_v;
    mode  = m;
    d     = dv;
    sin_l = sl;
    sin_r = sr;
    rot   = rv;
    @(posedge clk);
    #1;
    expect_now(name, eq, ec);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want summary before 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    // Async reset seen before any clock edge.
    #1 rst = 1'b1;
    #1 expect_now("reset_no_edge", 8'h00, 4'd0);
    @(negedge clk) rst = 1'b0;

    cyc("load_a5", 1, USR_LOAD, 8'hA5, 0, 0, 0, 8'hA5, 4'd8);
    cyc("shl_1", 1, USR_SHL, 8'h00, 0, 1, 0, 8'h4B, 4'd7);
    cyc("shl_2", 1, USR_SHL, 8'h00, 0, 1, 0, 8'h97, 4'd6);
    cyc("shl_3", 1, USR_SHL, 8'h00, 0, 1, 0, 8'h2F, 4'd5);

    cyc("reload_a5", 1, USR_LOAD, 8'hA5, 0, 0, 0, 8'hA5, 4'd8);
    cyc("shr_1", 1, USR_SHR, 8'h00, 0, 0, 0, 8'h52, 4'd7);
    cyc("shr_2", 1, USR_SHR, 8'h00, 0, 0, 0, 8'h29, 4'd6);
    cyc("shr_3", 1, USR_SHR, 8'h00, 0, 0, 0, 8'h14, 4'd5);
    cyc("shr_4", 1, USR_SHR, 8'h00, 0, 0, 0, 8'h0A, 4'd4);
    cyc("shr_5", 1, USR_SHR, 8'h00, 0, 0, 0, 8'h05, 4'd3);
    cyc("shr_6", 1, USR_SHR, 8'h00, 0, 0, 0, 8'h02, 4'd2);
    cyc("shr_7", 1, USR_SHR, 8'h00, 0, 0, 0, 8'h01, 4'd1);
    cyc("shr_8_drained", 1, USR_SHR, 8'h00, 0, 0, 0, 8'h00, 4'd0);
    cyc("shr_9_saturate", 1, USR_SHR, 8'h00, 0, 0, 0, 8'h00, 4'd0);

    cyc("load_mid", 1, USR_LOAD, 8'hA5, 0, 0, 0, 8'hA5, 4'd8);
    cyc("shl_mid_1", 1, USR_SHL, 8'h00, 0, 0, 0, 8'h4A, 4'd7);
    cyc("shl_mid_2", 1, USR_SHL, 8'h00, 0, 0, 0, 8'h94, 4'd6);
    for (int i = 0; i < 4; i++) begin
      cyc("en_low_hold", 0, USR_LOAD, 8'hFF, 1, 1, 0, 8'h94, 4'd6);
    end
    cyc("resume_shr", 1, USR_SHR, 8'h00, 1, 0, 0, 8'hCA, 4'd5);
    cyc("resume_shl", 1, USR_SHL, 8'h00, 0, 0, 0, 8'h94, 4'd4);

    // Reset pulse between edges, mid-drain.
    #2 rst = 1'b1;
    #1 expect_now("reset_mid_cycle", 8'h00, 4'd0);
    #1 rst = 1'b0;

    cyc("load_after_rst", 1, USR_LOAD, 8'hA5, 0, 0, 0, 8'hA5, 4'd8);
    cyc("shl_before_reload", 1, USR_SHL, 8'h00, 0, 1, 0, 8'h4B, 4'd7);
    cyc("reload_nonzero_cnt", 1, USR_LOAD, 8'h3C, 0, 0, 0, 8'h3C, 4'd8);
    cyc("hold_mode", 1, USR_HOLD, 8'hFF, 1, 1, 0, 8'h3C, 4'd8);

`ifdef USR_ROTATE_EN
    cyc("rot_load_81", 1, USR_LOAD, 8'h81, 0, 0, 0, 8'h81, 4'd8);
    cyc("rot_shl", 1, USR_SHL, 8'h00, 0, 0, 1, 8'h03, 4'd7);
    cyc("rot_reload_81", 1, USR_LOAD, 8'h81, 0, 0, 0, 8'h81, 4'd8);
    cyc("rot_shr", 1, USR_SHR, 8'h00, 1, 1, 1, 8'hC0, 4'd7);
`endif

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      #1;
    end
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
